// File: rtl/fir_mac_if.sv
// fir_mac_if: sample-window, coefficient-write and filtered-output bundle
// between the sample buffer / control plane (master) and the FIR MAC (slave).
interface fir_mac_if #(
  parameter int unsigned TAPS  = 256,
  parameter int unsigned IDX_W = 8
);
  logic                  trigger_in;
  logic [TAPS-1:0][15:0] samples_in;
  logic [IDX_W-1:0]      offset_in;
  logic                  coeff_wr_in;
  logic [IDX_W-1:0]      coeff_addr_in;
  logic [15:0]           coeff_data_in;
  logic [15:0]           signal_out;
  logic                  valid_out;
  logic                  busy_out;
  logic                  overrun_out;

  modport master (
    output trigger_in, samples_in, offset_in,
    output coeff_wr_in, coeff_addr_in, coeff_data_in,
    input  signal_out, valid_out, busy_out, overrun_out
  );

  modport slave (
    input  trigger_in, samples_in, offset_in,
    input  coeff_wr_in, coeff_addr_in, coeff_data_in,
    output signal_out, valid_out, busy_out, overrun_out
  );
endinterface

// File: rtl/fir_mac.sv
// fir_mac: sequential TAPS-tap FIR over a circular sample window, one MAC per
// cycle from newest to oldest sample, Q1.15 coefficients, saturated 16-bit
// output with a one-cycle valid pulse.
// Optional macro FIR_ROUND_EN: round half up before the final >>> 15.
module fir_mac #(
  parameter int unsigned TAPS  = 256,
  parameter int unsigned IDX_W = 8,
  parameter int unsigned ACC_W = 40
) (
  input  logic     clk_in,
  input  logic     rst_n_in,
  fir_mac_if.slave bus
);

  localparam int unsigned DATA_W = 16;
  localparam int unsigned PROD_W = 32;
  localparam logic [IDX_W-1:0]        LAST_K  = IDX_W'(TAPS - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32'sd32767);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32'sd32768);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_MAC,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                     state_q, state_d;
  logic [IDX_W-1:0]           base_q;
  logic [IDX_W-1:0]           k_q;
  logic signed [PROD_W-1:0]   prod_q;
  logic signed [ACC_W-1:0]    acc_q;
  logic [DATA_W-1:0]          signal_q;
  logic                       valid_q;
  logic                       busy_q;
  logic                       overrun_q;
  logic signed [DATA_W-1:0]   coeff_q [TAPS];

  logic [IDX_W-1:0]           tap_idx_c;
  logic signed [DATA_W-1:0]   sample_c;
  logic signed [PROD_W-1:0]   prod_c;
  logic signed [ACC_W-1:0]    sum_c;
  logic signed [ACC_W-1:0]    biased_c;
  logic signed [ACC_W-1:0]    shifted_c;
  logic [DATA_W-1:0]          sat_c;

  // State register
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.trigger_in) state_d = S_LATCH;
      S_LATCH: state_d = S_MAC;
      S_MAC:   if (k_q == LAST_K) state_d = S_DRAIN;
      S_DRAIN: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Tap address walks backwards from the newest sample, wrapping mod TAPS
  always_comb begin
    tap_idx_c = base_q - k_q;
    sample_c  = bus.samples_in[tap_idx_c];
    prod_c    = PROD_W'(coeff_q[k_q]) * PROD_W'(sample_c);
    sum_c     = acc_q + ACC_W'(prod_q);
`ifdef FIR_ROUND_EN
    biased_c  = sum_c + ACC_W'(32'sd16384);
`else
    biased_c  = sum_c;
`endif
    shifted_c = biased_c >>> 15;
    if (shifted_c > SAT_MAX)      sat_c = 16'h7FFF;
    else if (shifted_c < SAT_MIN) sat_c = 16'h8000;
    else                          sat_c = DATA_W'(shifted_c);
  end

  // Coefficient bank: writable only while idle
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < int'(TAPS); i++) coeff_q[i] <= '0;
    end else if (bus.coeff_wr_in && (state_q == S_IDLE)) begin
      coeff_q[bus.coeff_addr_in] <= bus.coeff_data_in;
    end
  end

  // MAC datapath and registered outputs; the final sum is formed in DRAIN so
  // the result is already on signal_out while in DONE
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      base_q    <= '0;
      k_q       <= '0;
      prod_q    <= '0;
      acc_q     <= '0;
      signal_q  <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      valid_q <= (state_q == S_DRAIN);
      busy_q  <= (state_d != S_IDLE);
      if (bus.trigger_in && (state_q != S_IDLE)) overrun_q <= 1'b1;
      case (state_q)
        S_LATCH: begin
          base_q <= bus.offset_in - IDX_W'(1);
          k_q    <= '0;
          prod_q <= '0;
          acc_q  <= '0;
        end
        S_MAC: begin
          prod_q <= prod_c;
          acc_q  <= sum_c;
          k_q    <= k_q + IDX_W'(1);
        end
        S_DRAIN: begin
          acc_q    <= sum_c;
          signal_q <= sat_c;
        end
        default: ;
      endcase
    end
  end

  assign bus.signal_out  = signal_q;
  assign bus.valid_out   = valid_q;
  assign bus.busy_out    = busy_q;
  assign bus.overrun_out = overrun_q;

endmodule

// File: tb/tb_fir_mac.sv
// tb_fir_mac: directed test-plan cases plus randomized runs against a plain
// convolution reference model.
module tb_fir_mac;

  localparam int TAPS = 256;

  logic clk_in   = 1'b0;
  logic rst_n_in = 1'b0;

  fir_mac_if bus ();

  fir_mac dut (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .bus      (bus)
  );

  always #5 clk_in = ~clk_in;

  int errors = 0;
  int checks = 0;

  int coeff_m [TAPS];
  int samp_m  [TAPS];
  int offset_m;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: y = sat16((sum_k c[k]*x[newest-k] [+2^14]) >>> 15)
  function automatic int model_fir();
    longint acc = 0;
    for (int k = 0; k < TAPS; k++)
      acc += longint'(coeff_m[k]) * longint'(samp_m[(offset_m - 1 - k) & (TAPS - 1)]);
`ifdef FIR_ROUND_EN
    acc += 16384;
`endif
    acc = acc >>> 15;
    if (acc > 32767) acc = 32767;
    if (acc < -32768) acc = -32768;
    return int'(acc);
  endfunction

  function automatic int rnd16();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  function automatic int sig_out();
    return int'($signed(bus.signal_out));
  endfunction

  task automatic apply_samples();
    for (int i = 0; i < TAPS; i++) bus.samples_in[i] = 16'(samp_m[i]);
    bus.offset_in = 8'(offset_m);
  endtask

  task automatic write_coeff(input int k, input int v);
    bus.coeff_wr_in   = 1'b1;
    bus.coeff_addr_in = 8'(k);
    bus.coeff_data_in = 16'(v);
    @(posedge clk_in); #1;
    bus.coeff_wr_in   = 1'b0;
    coeff_m[k] = v;
  endtask

  task automatic clear_model_coeffs();
    for (int k = 0; k < TAPS; k++) coeff_m[k] = 0;
  endtask

  // One filter run; wr_at / trig_at / rst_at are edge offsets after the
  // triggering edge (negative = unused).
  task automatic run(input string tag, input int wr_at, input int trig_at,
                     input int rst_at, output int result);
    int first_valid = -1;
    int valid_cnt   = 0;
    int n           = 0;
    bit reset_hit   = 0;
    result = 0;
    bus.trigger_in = 1'b1;
    @(posedge clk_in); #1;
    bus.trigger_in = 1'b0;
    check({tag, "_busy_rise"}, int'(bus.busy_out), 1);
    for (n = 1; n < 400; n++) begin
      @(posedge clk_in); #1;
      bus.coeff_wr_in = 1'b0;
      bus.trigger_in  = 1'b0;
      if (bus.valid_out) begin
        if (first_valid < 0) first_valid = n;
        valid_cnt++;
      end
      if (!bus.busy_out) break;
      if (n == wr_at) begin
        bus.coeff_wr_in   = 1'b1;
        bus.coeff_addr_in = 8'd0;
        bus.coeff_data_in = 16'h1234;
      end
      if (n == trig_at) bus.trigger_in = 1'b1;
      if (n == rst_at) begin
        rst_n_in = 1'b0;
        #1;
        reset_hit = 1;
        check({tag, "_rst_sig"}, sig_out(), 0);
        check({tag, "_rst_valid"}, int'(bus.valid_out), 0);
        check({tag, "_rst_busy"}, int'(bus.busy_out), 0);
        check({tag, "_rst_ovr"}, int'(bus.overrun_out), 0);
        @(posedge clk_in); #1;
        check({tag, "_rst_novalid"}, int'(bus.valid_out), 0);
        rst_n_in = 1'b1;
        clear_model_coeffs();
        break;
      end
    end
    if (!reset_hit) begin
      check({tag, "_latency"}, first_valid, 258);
      check({tag, "_valid_cnt"}, valid_cnt, 1);
      check({tag, "_busy_fall"}, n, 259);
      result = sig_out();
      check({tag, "_model"}, result, model_fir());
      @(posedge clk_in); #1;
      check({tag, "_hold"}, sig_out(), result);
    end
  endtask

  int res;

  initial begin
    bus.trigger_in    = 1'b0;
    bus.coeff_wr_in   = 1'b0;
    bus.coeff_addr_in = '0;
    bus.coeff_data_in = '0;
    clear_model_coeffs();
    for (int i = 0; i < TAPS; i++) samp_m[i] = 0;
    offset_m = 0;
    apply_samples();

    #12;
    check("reset_sig", sig_out(), 0);
    check("reset_valid", int'(bus.valid_out), 0);
    check("reset_busy", int'(bus.busy_out), 0);
    check("reset_ovr", int'(bus.overrun_out), 0);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    @(posedge clk_in); #1;

    // Impulse: only coeff[0], newest sample 1000
    write_coeff(0, 16'h4000);
    offset_m = 37;
    for (int i = 0; i < TAPS; i++) samp_m[i] = 123;
    samp_m[36] = 1000;
    apply_samples();
    run("impulse", -1, -1, -1, res);
    check("impulse_val", res, 500);

    // Delay tap across the wrap: newest at slot 1, k=3 lands on slot 254
    write_coeff(0, 0);
    write_coeff(3, 16'h4000);
    offset_m = 2;
    for (int i = 0; i < TAPS; i++) samp_m[i] = 0;
    samp_m[255] = 777;
    samp_m[254] = -2000;
    apply_samples();
    run("wrap", -1, -1, -1, res);
    check("wrap_val", res, -1000);

    // Saturation both ways
    for (int k = 0; k < TAPS; k++) write_coeff(k, 16'h7FFF);
    for (int i = 0; i < TAPS; i++) samp_m[i] = 32767;
    apply_samples();
    run("sat_pos", -1, -1, -1, res);
    check("sat_pos_val", res, 32767);
    for (int i = 0; i < TAPS; i++) samp_m[i] = -32768;
    apply_samples();
    run("sat_neg", -1, -1, -1, res);
    check("sat_neg_val", res, -32768);

    // Rounding of exactly one half LSB
    for (int k = 0; k < TAPS; k++) write_coeff(k, 0);
    write_coeff(0, 1);
    offset_m = 100;
    for (int i = 0; i < TAPS; i++) samp_m[i] = 0;
    samp_m[99] = 16'h4000;
    apply_samples();
    run("round", -1, -1, -1, res);
`ifdef FIR_ROUND_EN
    check("round_val", res, 1);
`else
    check("round_val", res, 0);
`endif

    // Randomized runs
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < TAPS; k++)
        write_coeff(k, (r[0]) ? rnd16() : int'($urandom_range(0, 4095)) - 2048);
      for (int i = 0; i < TAPS; i++) samp_m[i] = rnd16();
      offset_m = int'($urandom_range(0, TAPS - 1));
      apply_samples();
      run($sformatf("rand%0d", r), -1, -1, -1, res);
    end
    check("ovr_before", int'(bus.overrun_out), 0);

    // Overrun plus dropped write while busy; result must still match the bank
    run("overrun", 50, 100, -1, res);
    check("ovr_set", int'(bus.overrun_out), 1);
    run("after_ovr", -1, -1, -1, res);
    check("ovr_sticky", int'(bus.overrun_out), 1);

    // Write and trigger in the same idle cycle: the write is used by this run
    coeff_m[5] = 16'h2000;
    bus.coeff_wr_in   = 1'b1;
    bus.coeff_addr_in = 8'd5;
    bus.coeff_data_in = 16'h2000;
    run("wr_trig", -1, -1, -1, res);

    // Reset mid-MAC, then a fresh run with a new bank
    run("rst_mid", -1, -1, 120, res);
    @(posedge clk_in); #1;
    for (int k = 0; k < TAPS; k++) write_coeff(k, rnd16());
    for (int i = 0; i < TAPS; i++) samp_m[i] = rnd16();
    offset_m = 0;
    apply_samples();
    run("post_rst", -1, -1, -1, res);
    check("post_rst_ovr", int'(bus.overrun_out), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
